// File: rtl/pipeline_hazard_control.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_control
//
// Pipeline control unit for the five-stage CPU. It decides, every cycle, what
// each pipeline latch does (load, hold or load a bubble) and whether the PC
// may advance. It also tracks data-memory waits and halt in a small FSM, and
// keeps two saturating debug counters.
//
// Ports:
//   CLK               in   system clock, rising edge
//   nRST              in   synchronous active-low reset
//   ihit              in   instruction cache delivered a valid instruction
//   dhit              in   data cache finished the MEM-stage access
//   dmemREN_mem       in   MEM-stage instruction reads data memory
//   dmemWEN_mem       in   MEM-stage instruction writes data memory
//   memread_ex        in   EX-stage instruction is a load
//   rd_ex      [4:0]  in   EX-stage destination register
//   rs_dec     [4:0]  in   decode-stage source register rs
//   rt_dec     [4:0]  in   decode-stage source register rt
//   branch_taken_mem  in   branch/jump resolved taken in MEM
//   halt_mem          in   halt instruction in MEM
//   fd_state   [1:0]  out  fetch/decode latch control
//   de_state   [1:0]  out  decode/execute latch control
//   em_state   [1:0]  out  execute/memory latch control
//   mw_state   [1:0]  out  memory/writeback latch control
//                          (00 enable, 01 stall/hold, 10 nop/load zeros)
//   pc_en             out  PC register write enable
//   halted            out  CPU halted
//   stall_cycles [15:0] out saturating count of non-halted cycles with pc_en=0
//   flush_count  [15:0] out saturating count of taken-branch flushes
// ---------------------------------------------------------------------------
module pipeline_hazard_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmemREN_mem,
  input  logic        dmemWEN_mem,
  input  logic        memread_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rs_dec,
  input  logic [4:0]  rt_dec,
  input  logic        branch_taken_mem,
  input  logic        halt_mem,
  output logic [1:0]  fd_state,
  output logic [1:0]  de_state,
  output logic [1:0]  em_state,
  output logic [1:0]  mw_state,
  output logic        pc_en,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [1:0] PIPE_ENABLE = 2'b00;
  localparam logic [1:0] PIPE_STALL  = 2'b01;
  localparam logic [1:0] PIPE_NOP    = 2'b10;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;

  logic        dmem_wait;
  logic        load_use;
  logic        flush_sel;
  logic        stall_inc;
  logic        flush_inc;

  // A MEM-stage access that has not completed freezes the whole pipe.
  assign dmem_wait = (dmemREN_mem | dmemWEN_mem) & ~dhit;

  // Register 0 is hardwired zero, so a load targeting it never creates a
  // dependency.
  assign load_use = memread_ex && (rd_ex != 5'd0) &&
                    ((rd_ex == rs_dec) || (rd_ex == rt_dec));

  // Latch control and next state, evaluated in priority order. DWAIT and RUN
  // share the same rules: a DWAIT cycle without dhit re-selects the memory
  // wait, and the dhit cycle falls through to the lower-priority rules.
  always_comb begin
    fd_state   = PIPE_ENABLE;
    de_state   = PIPE_ENABLE;
    em_state   = PIPE_ENABLE;
    mw_state   = PIPE_ENABLE;
    pc_en      = 1'b1;
    halted     = 1'b0;
    flush_sel  = 1'b0;
    state_next = RUN;

    if (!nRST) begin
      // Reset overrides everything, including HALTED and DWAIT.
      fd_state   = PIPE_NOP;
      de_state   = PIPE_NOP;
      em_state   = PIPE_NOP;
      mw_state   = PIPE_NOP;
      pc_en      = 1'b0;
      halted     = 1'b0;
      state_next = RUN;
    end else if (state_reg == HALTED) begin
      fd_state   = PIPE_STALL;
      de_state   = PIPE_STALL;
      em_state   = PIPE_STALL;
      mw_state   = PIPE_STALL;
      pc_en      = 1'b0;
      halted     = 1'b1;
      state_next = HALTED;
    end else if (halt_mem) begin
      // Let the halt retire into writeback, squash everything younger.
      fd_state   = PIPE_NOP;
      de_state   = PIPE_NOP;
      em_state   = PIPE_NOP;
      mw_state   = PIPE_ENABLE;
      pc_en      = 1'b0;
      state_next = HALTED;
    end else if (dmem_wait) begin
      // Checked before the branch so a branch that also touches memory
      // waits for dhit first, then flushes.
      fd_state   = PIPE_STALL;
      de_state   = PIPE_STALL;
      em_state   = PIPE_STALL;
      mw_state   = PIPE_STALL;
      pc_en      = 1'b0;
      state_next = DWAIT;
    end else if (branch_taken_mem) begin
      // The three younger instructions are wrong-path; PC loads the target.
      fd_state   = PIPE_NOP;
      de_state   = PIPE_NOP;
      em_state   = PIPE_NOP;
      mw_state   = PIPE_ENABLE;
      pc_en      = 1'b1;
      flush_sel  = 1'b1;
    end else if (load_use) begin
      // Hold the dependent instruction in decode and put a bubble behind
      // the load; next cycle the load is in MEM and forwarding covers it.
      fd_state   = PIPE_STALL;
      de_state   = PIPE_NOP;
      em_state   = PIPE_ENABLE;
      mw_state   = PIPE_ENABLE;
      pc_en      = 1'b0;
    end else if (!ihit) begin
      // Fetch has nothing valid yet: feed a bubble into decode.
      fd_state   = PIPE_NOP;
      de_state   = PIPE_ENABLE;
      em_state   = PIPE_ENABLE;
      mw_state   = PIPE_ENABLE;
      pc_en      = 1'b0;
    end
  end

  assign stall_inc = (state_reg != HALTED) && !pc_en &&
                     (stall_cycles_reg != 16'hFFFF);
  assign flush_inc = flush_sel && (flush_count_reg != 16'hFFFF);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg        <= RUN;
      stall_cycles_reg <= 16'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (stall_inc) begin
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      end
      if (flush_inc) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
module tb_pipeline_hazard_control;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic        dhit;
  logic        dmemREN_mem;
  logic        dmemWEN_mem;
  logic        memread_ex;
  logic [4:0]  rd_ex;
  logic [4:0]  rs_dec;
  logic [4:0]  rt_dec;
  logic        branch_taken_mem;
  logic        halt_mem;
  logic [1:0]  fd_state;
  logic [1:0]  de_state;
  logic [1:0]  em_state;
  logic [1:0]  mw_state;
  logic        pc_en;
  logic        halted;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [9:0]  ctl;   // {fd, de, em, mw, pc_en, halted}
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  exp_t sb_q[$];

  pipeline_hazard_control dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .ihit             (ihit),
    .dhit             (dhit),
    .dmemREN_mem      (dmemREN_mem),
    .dmemWEN_mem      (dmemWEN_mem),
    .memread_ex       (memread_ex),
    .rd_ex            (rd_ex),
    .rs_dec           (rs_dec),
    .rt_dec           (rt_dec),
    .branch_taken_mem (branch_taken_mem),
    .halt_mem         (halt_mem),
    .fd_state         (fd_state),
    .de_state         (de_state),
    .em_state         (em_state),
    .mw_state         (mw_state),
    .pc_en            (pc_en),
    .halted           (halted),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    ihit             = 1'b1;
    dhit             = 1'b0;
    dmemREN_mem      = 1'b0;
    dmemWEN_mem      = 1'b0;
    memread_ex       = 1'b0;
    rd_ex            = 5'd0;
    rs_dec           = 5'd0;
    rt_dec           = 5'd0;
    branch_taken_mem = 1'b0;
    halt_mem         = 1'b0;
  endtask

  // Push the expectation for the inputs just driven, sample on the falling
  // edge, compare against the popped entry, then step past the rising edge.
  task automatic check(input string tag,
                       input logic [1:0] fd, input logic [1:0] de,
                       input logic [1:0] em, input logic [1:0] mw,
                       input logic pc, input logic h,
                       input logic [15:0] st, input logic [15:0] fl);
    exp_t e;
    logic [9:0] obs;
    e.tag = tag;
    e.ctl = {fd, de, em, mw, pc, h};
    e.st  = st;
    e.fl  = fl;
    sb_q.push_back(e);
    @(negedge CLK);
    e   = sb_q.pop_front();
    obs = {fd_state, de_state, em_state, mw_state, pc_en, halted};
    checks++;
    assert (obs === e.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
    end
    checks++;
    assert (stall_cycles === e.st) else begin
      failures++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, stall_cycles, e.st);
    end
    checks++;
    assert (flush_count === e.fl) else begin
      failures++;
      $error("FAIL %s flush_count observed=%0d expected=%0d", e.tag, flush_count, e.fl);
    end
    $display("step %-14s ctl=%b stall=%0d flush=%0d", e.tag, obs, stall_cycles, flush_count);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    idle();
    @(posedge CLK);
    #1;

    // Reset in force: all bubbles, PC frozen
    check("reset",        2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 16'd0, 16'd0);
    nRST = 1'b1;
    check("run_idle",     2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 16'd0);

    // Load-use on rs, then on rt, then rd=0 (no stall)
    memread_ex = 1'b1; rd_ex = 5'd5; rs_dec = 5'd5; rt_dec = 5'd0;
    check("loaduse_rs",   2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'd0, 16'd0);
    idle();
    check("after_lu",     2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd1, 16'd0);
    memread_ex = 1'b1; rd_ex = 5'd7; rs_dec = 5'd3; rt_dec = 5'd7;
    check("loaduse_rt",   2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 16'd1, 16'd0);
    memread_ex = 1'b1; rd_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0;
    check("rd_zero",      2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd2, 16'd0);

    // Data-memory wait: three misses, then the hit
    idle(); dmemREN_mem = 1'b1; dhit = 1'b0;
    check("dwait1",       2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 16'd2, 16'd0);
    check("dwait2",       2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 16'd3, 16'd0);
    check("dwait3",       2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 16'd4, 16'd0);
    dhit = 1'b1;
    check("dhit",         2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd5, 16'd0);

    // Branch beats a concurrent load-use match
    idle(); branch_taken_mem = 1'b1;
    memread_ex = 1'b1; rd_ex = 5'd9; rs_dec = 5'd9;
    check("branch_lu",    2'b10, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 16'd5, 16'd0);
    idle();
    check("after_br",     2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd5, 16'd1);

    // Branch with a store: waits for dhit, then flushes
    branch_taken_mem = 1'b1; dmemWEN_mem = 1'b1; dhit = 1'b0;
    check("br_dwait",     2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 16'd5, 16'd1);
    dhit = 1'b1;
    check("br_dhit",      2'b10, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 16'd6, 16'd1);

    // Instruction cache miss
    idle(); ihit = 1'b0;
    check("imiss",        2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'd6, 16'd2);

    // Halt beats pending data access, then stays halted
    idle(); halt_mem = 1'b1; dmemREN_mem = 1'b1; dhit = 1'b0;
    check("halt_mem",     2'b10, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 16'd7, 16'd2);
    idle();
    check("halted1",      2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'd8, 16'd2);
    branch_taken_mem = 1'b1; ihit = 1'b0;
    check("halted2",      2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 16'd8, 16'd2);

    // Reset from HALTED
    idle(); nRST = 1'b0;
    check("rst_halted",   2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 16'd8, 16'd2);
    nRST = 1'b1;
    check("post_rst",     2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 16'd0);

    // Reset in the middle of a data wait
    dmemREN_mem = 1'b1; dhit = 1'b0;
    check("dwait_pre",    2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, 16'd0, 16'd0);
    nRST = 1'b0;
    check("rst_dwait",    2'b10, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 16'd1, 16'd0);
    idle(); nRST = 1'b1;
    check("post_rst2",    2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'd0, 16'd0);

    // Saturation of stall_cycles
    ihit = 1'b0;
    for (int i = 0; i < 65534; i++) @(posedge CLK);
    #1;
    check("sat_m1",       2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'd65534, 16'd0);
    check("sat_max",      2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 16'hFFFF, 16'd0);
    for (int i = 0; i < 5; i++) @(posedge CLK);
    #1;
    idle();
    check("sat_hold",     2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 16'hFFFF, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
